// File: rtl/delay_arbiter_pkg.sv
// Shared definitions for the delay arbiter: FSM state encoding and the
// width helper used to size the round-robin pointer and grant index.
package delay_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Width needed to index R requesters; never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/delay_arbiter_if.sv
// Requester-side bundle of the delay arbiter. The master modport is the
// group of control FSMs asking for wait states; the slave is the arbiter.
interface delay_arbiter_if #(
    parameter int N = 4,
    parameter int R = 2
);
    logic [R-1:0]       req;
    logic [R*(N-1)-1:0] len;
    logic [R-1:0]       gnt;
    logic [R-1:0]       done;
    logic               busy;

    modport master (
        output req,
        output len,
        input  gnt,
        input  done,
        input  busy
    );

    modport slave (
        input  req,
        input  len,
        output gnt,
        output done,
        output busy
    );
endinterface

// File: rtl/delay_arbiter_counter.sv
// Shared N-bit up-counter. The MSB doubles as the overflow flag, so a load
// of 2^(N-1) - len reaches the flag after exactly len increments.
module counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic [N-1:0] in_i,
    input  logic         ld_i,
    input  logic         clr_i,
    input  logic         cnten_i,
    output logic         ov_o
);
    logic [N-1:0] cnt_q;

    // Count register: clear beats load beats increment.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {N{1'b0}};
        end else if (clr_i) begin
            cnt_q <= {N{1'b0}};
        end else if (ld_i) begin
            cnt_q <= in_i;
        end else if (cnten_i) begin
            cnt_q <= cnt_q + {{(N-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign ov_o = cnt_q[N-1];
endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter that lends one shared counter to R requesters, each
// asking for a programmable delay. The granted requester's length is latched
// at grant time, so later changes on req/len cannot disturb a service.
module delay_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int R = 2
) (
    input  logic           clk,
    input  logic           rst,
    delay_arbiter_if.slave bus
);
    localparam int SEL_W = clog2(R);
    localparam int LW    = N - 1;
    localparam logic [N-1:0] LOAD_BASE = {1'b1, {(N-1){1'b0}}};

    state_e           state_q, state_d;
    logic [R-1:0]     gnt_q, gnt_d;
    logic [R-1:0]     done_q, done_d;
    logic             busy_q, busy_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [LW-1:0]    len_q, len_d;

    logic             pick_valid_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic [LW-1:0]    pick_len_s;
    logic [N-1:0]     load_val_s;
    logic             ld_s, clr_s, cnten_s, ov_s;
    logic             cnt_rst_s;

    // First set request at or after ptr, wrapping; MSB of result is valid.
    function automatic logic [SEL_W:0] rr_pick(input logic [R-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] win;
        found = 1'b0;
        win   = {SEL_W{1'b0}};
        for (int k = 0; k < R; k++) begin
            idx = SEL_W'((int'(ptr) + k) % R);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // Arbitration winner and its length slice from the live inputs.
    always_comb begin
        {pick_valid_s, pick_idx_s} = rr_pick(bus.req, ptr_q);
        pick_len_s = {LW{1'b0}};
        for (int i = 0; i < R; i++) begin
            if (SEL_W'(i) == pick_idx_s) begin
                pick_len_s = bus.len[i*LW +: LW];
            end else begin
                pick_len_s = pick_len_s;
            end
        end
    end

    // Load value 2^(N-1) - len, so len = 0 starts with the flag already set.
    assign load_val_s = LOAD_BASE - {1'b0, len_q};

    // Next-state and registered-output logic of the service FSM.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = {R{1'b0}};
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    sel_d             = pick_idx_s;
                    len_d             = pick_len_s;
                    gnt_d             = {R{1'b0}};
                    gnt_d[pick_idx_s] = 1'b1;
                    state_d           = LOAD;
                end else begin
                    gnt_d   = {R{1'b0}};
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = COUNT;
            end
            COUNT: begin
                if (ov_s) begin
                    done_d[sel_q] = 1'b1;
                    state_d       = DONE;
                end else begin
                    state_d = COUNT;
                end
            end
            DONE: begin
                if (int'(sel_q) == R - 1) begin
                    ptr_d = {SEL_W{1'b0}};
                end else begin
                    ptr_d = sel_q + {{(SEL_W-1){1'b0}}, 1'b1};
                end
                gnt_d   = {R{1'b0}};
                state_d = IDLE;
            end
            default: begin
                gnt_d   = {R{1'b0}};
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any service without a done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= {R{1'b0}};
            done_q  <= {R{1'b0}};
            busy_q  <= 1'b0;
            ptr_q   <= {SEL_W{1'b0}};
            sel_q   <= {SEL_W{1'b0}};
            len_q   <= {LW{1'b0}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
        end
    end

    // Counter strobes decoded from state; at most one is active per cycle.
    always_comb begin
        ld_s    = 1'b0;
        clr_s   = 1'b0;
        cnten_s = 1'b0;
        case (state_q)
            LOAD:    ld_s    = 1'b1;
            COUNT:   cnten_s = !ov_s;
            DONE:    clr_s   = 1'b1;
            default: ld_s    = 1'b0;
        endcase
    end

    assign cnt_rst_s = ~rst;

    counter #(.N(N)) u_counter (
        .clk     (clk),
        .rst_i   (cnt_rst_s),
        .in_i    (load_val_s),
        .ld_i    (ld_s),
        .clr_i   (clr_s),
        .cnten_i (cnten_s),
        .ov_o    (ov_s)
    );

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter (N=4, R=2). Expected events are queued
// with their cycle number when stimulus is applied and compared when the
// cycle is reached.
module tb_delay_arbiter;
    localparam int K_GNT   = 0;
    localparam int K_DONE  = 1;
    localparam int K_BUSY  = 2;
    localparam int K_CNT   = 3;
    localparam int K_CNTEN = 4;

    typedef struct {
        int         cyc;
        int         kind;
        logic [3:0] val;
        string      tag;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   t;
    exp_t sb[$];

    delay_arbiter_if #(.N(4), .R(2)) bus ();

    delay_arbiter #(.N(4), .R(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] sample(input int kind);
        case (kind)
            K_GNT:   return {2'b00, bus.gnt};
            K_DONE:  return {2'b00, bus.done};
            K_BUSY:  return {3'b000, bus.busy};
            K_CNT:   return dut.u_counter.cnt_q;
            K_CNTEN: return {3'b000, dut.cnten_s};
            default: return 4'hx;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic expect_at(input int c, input int kind, input logic [3:0] v, input string tag);
        sb.push_back('{c, kind, v, tag});
    endtask

    // Full timeline of one service whose request is sampled in cycle t0.
    task automatic push_service(input int t0, input int idx, input int len);
        logic [3:0] oh;
        oh = 4'd1 << idx;
        expect_at(t0 + 1,       K_GNT,  oh,             "gnt_on");
        expect_at(t0 + 1,       K_BUSY, 4'd1,           "busy_on");
        expect_at(t0 + 2,       K_CNT,  4'(8 - len),    "cnt_load");
        expect_at(t0 + 2 + len, K_CNT,  4'd8,           "cnt_ov");
        expect_at(t0 + 2 + len, K_DONE, 4'd0,           "done_early");
        expect_at(t0 + 3 + len, K_DONE, oh,             "done_pulse");
        expect_at(t0 + 3 + len, K_GNT,  oh,             "gnt_hold");
        expect_at(t0 + 4 + len, K_GNT,  4'd0,           "gnt_off");
        expect_at(t0 + 4 + len, K_DONE, 4'd0,           "done_off");
        expect_at(t0 + 4 + len, K_BUSY, 4'd0,           "busy_off");
        expect_at(t0 + 4 + len, K_CNT,  4'd0,           "cnt_clr");
    endtask

    // Advance one clock, sample 1 ns later and retire due scoreboard entries.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i].tag, sample(sb[i].kind), sb[i].val);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                vectors++;
                miscompares++;
                $error("FAIL %s missed cycle=%0d", sb[i].tag, sb[i].cyc);
                sb.delete(i);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    initial begin
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        bus.req     = 2'b00;
        bus.len     = 6'd0;

        // Reset state.
        #3;
        check("rst_gnt",  {2'b00, bus.gnt},  4'd0);
        check("rst_done", {2'b00, bus.done}, 4'd0);
        check("rst_busy", {3'b000, bus.busy}, 4'd0);
        check("rst_cnt",  dut.u_counter.cnt_q, 4'd0);
        run(2);
        #4 rst = 1'b1;
        step();

        // Single request, len0 = 5; request withdrawn after the grant.
        t = cyc;
        bus.req = 2'b01;
        bus.len[2:0] = 3'd5;
        push_service(t, 0, 5);
        step();
        bus.req = 2'b00;
        run(9);

        // Zero length on requester 1: counter loaded 8, no increments.
        t = cyc;
        bus.req = 2'b10;
        bus.len[5:3] = 3'd0;
        push_service(t, 1, 0);
        expect_at(t + 2, K_CNTEN, 4'd0, "zl_cnten");
        expect_at(t + 3, K_CNT,   4'd8, "zl_cnt_hold");
        step();
        bus.req = 2'b00;
        run(5);

        // Contention fairness: both held, grants alternate 0, 1, 0.
        t = cyc;
        bus.req = 2'b11;
        bus.len = {3'd2, 3'd2};
        push_service(t,      0, 2);
        push_service(t + 6,  1, 2);
        push_service(t + 12, 0, 2);
        run(13);
        bus.req = 2'b00;
        run(7);

        // Withdrawal plus max length on requester 0 (ptr is now 1).
        t = cyc;
        bus.req = 2'b01;
        bus.len[2:0] = 3'd7;
        push_service(t, 0, 7);
        expect_at(t + 3, K_CNT, 4'd2, "max_cnt_step");
        expect_at(t + 8, K_CNT, 4'd7, "max_cnt_pre_ov");
        step();
        bus.req = 2'b00;
        run(2);
        bus.len[2:0] = 3'd1;
        run(9);

        // Async reset in the middle of COUNT.
        t = cyc;
        bus.req = 2'b01;
        bus.len[2:0] = 3'd4;
        expect_at(t + 1, K_GNT, 4'd1, "ar_gnt_on");
        expect_at(t + 2, K_CNT, 4'd4, "ar_cnt_load");
        step();
        bus.req = 2'b00;
        run(2);
        #2 rst = 1'b0;
        #1;
        check("ar_gnt",  {2'b00, bus.gnt},  4'd0);
        check("ar_done", {2'b00, bus.done}, 4'd0);
        check("ar_busy", {3'b000, bus.busy}, 4'd0);
        check("ar_cnt",  dut.u_counter.cnt_q, 4'd0);
        bus.req = 2'b10;
        bus.len[5:3] = 3'd3;
        step();
        check("ar_hold_gnt", {2'b00, bus.gnt}, 4'd0);
        check("ar_hold_cnt", dut.u_counter.cnt_q, 4'd0);
        #4 rst = 1'b1;
        t = cyc;
        push_service(t, 1, 3);
        step();
        bus.req = 2'b00;
        run(9);

        if (sb.size() != 0) begin
            vectors     += sb.size();
            miscompares += sb.size();
            $error("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
